// File: rtl/axi_aw_route_if.sv
// Bundle of the master-side and slave-side AW/W/B signals seen by axi_aw_route.
// The router uses the slave modport and the upstream/downstream agents use the master modport.
interface axi_aw_route_if #(
    parameter int NUM_S  = 2,
    parameter int ADDR_W = 32,
    parameter int ID_W   = 4,
    parameter int MID_W  = 4,
    parameter int LEN_W  = 4,
    parameter int SIZE_W = 3,
    parameter int DATA_W = 32
);
    localparam int SID_W = ID_W + MID_W;

    logic [ID_W-1:0]     AWID_M;
    logic [ADDR_W-1:0]   AWADDR_M;
    logic [LEN_W-1:0]    AWLEN_M;
    logic [SIZE_W-1:0]   AWSIZE_M;
    logic [1:0]          AWBURST_M;
    logic                AWVALID_M, AWREADY_M;
    logic [DATA_W-1:0]   WDATA_M;
    logic [DATA_W/8-1:0] WSTRB_M;
    logic                WLAST_M, WVALID_M, WREADY_M;
    logic [ID_W-1:0]     BID_M;
    logic [1:0]          BRESP_M;
    logic                BVALID_M, BREADY_M;

    logic [SID_W-1:0]    AWID_S;
    logic [ADDR_W-1:0]   AWADDR_S;
    logic [LEN_W-1:0]    AWLEN_S;
    logic [SIZE_W-1:0]   AWSIZE_S;
    logic [1:0]          AWBURST_S;
    logic [NUM_S-1:0]    AWVALID_S, AWREADY_S;
    logic [DATA_W-1:0]   WDATA_S;
    logic [DATA_W/8-1:0] WSTRB_S;
    logic                WLAST_S;
    logic [NUM_S-1:0]    WVALID_S, WREADY_S;
    logic [NUM_S-1:0][SID_W-1:0] BID_S;
    logic [NUM_S-1:0][1:0]       BRESP_S;
    logic [NUM_S-1:0]    BVALID_S, BREADY_S;

    modport slave (
        input  AWID_M, AWADDR_M, AWLEN_M, AWSIZE_M, AWBURST_M, AWVALID_M,
        output AWREADY_M,
        input  WDATA_M, WSTRB_M, WLAST_M, WVALID_M,
        output WREADY_M, BID_M, BRESP_M, BVALID_M,
        input  BREADY_M,
        output AWID_S, AWADDR_S, AWLEN_S, AWSIZE_S, AWBURST_S, AWVALID_S,
        input  AWREADY_S,
        output WDATA_S, WSTRB_S, WLAST_S, WVALID_S,
        input  WREADY_S, BID_S, BRESP_S, BVALID_S,
        output BREADY_S
    );

    modport master (
        output AWID_M, AWADDR_M, AWLEN_M, AWSIZE_M, AWBURST_M, AWVALID_M,
        input  AWREADY_M,
        output WDATA_M, WSTRB_M, WLAST_M, WVALID_M,
        input  WREADY_M, BID_M, BRESP_M, BVALID_M,
        output BREADY_M,
        input  AWID_S, AWADDR_S, AWLEN_S, AWSIZE_S, AWBURST_S, AWVALID_S,
        output AWREADY_S,
        input  WDATA_S, WSTRB_S, WLAST_S, WVALID_S,
        output WREADY_S, BID_S, BRESP_S, BVALID_S,
        input  BREADY_S
    );
endinterface

// File: rtl/axi_aw_route.sv
// Single-outstanding AXI write router: decodes AWADDR onto one of NUM_S slaves or an
// internal DECERR slave, steers AW/W/B to that port and prefixes slave-side IDs with MID.
module axi_aw_route #(
    parameter int NUM_S  = 2,
    parameter int ADDR_W = 32,
    parameter int ID_W   = 4,
    parameter int MID_W  = 4,
    parameter int MID    = 0,
    parameter int LEN_W  = 4,
    parameter int SIZE_W = 3,
    parameter int DATA_W = 32,
    parameter logic [NUM_S*ADDR_W-1:0] SLV_BASE = {32'h0001_0000, 32'h0000_0000},
    parameter logic [NUM_S*ADDR_W-1:0] SLV_MASK = {32'hFFFF_0000, 32'hFFFF_0000}
) (
    input  logic          ACLK,
    input  logic          ARESET,
    axi_aw_route_if.slave bus,
    output logic          wlast_err
);
    localparam int SEL_W = $clog2(NUM_S + 1);
    // Index one past the last real slave selects the internal DECERR responder.
    localparam logic [SEL_W-1:0] DEF = SEL_W'(NUM_S);

    typedef enum logic [1:0] {IDLE, WDATA, WRESP} state_t;

    state_t           state_q, state_d;
    logic [SEL_W-1:0] sel_q, sel_d, dec;
    logic [LEN_W-1:0] cnt_q, cnt_d, len_q, len_d;
    logic [ID_W-1:0]  id_q, id_d;
    logic             wlast_err_q, wlast_err_d;
    logic             aw_rdy, w_rdy, b_vld;
    logic             unused_bid;

    assign unused_bid    = ^bus.BID_S;
    assign wlast_err     = wlast_err_q;

    assign bus.AWID_S    = {MID_W'(MID), bus.AWID_M};
    assign bus.AWADDR_S  = ADDR_W'(bus.AWADDR_M);
    assign bus.AWLEN_S   = LEN_W'(bus.AWLEN_M);
    assign bus.AWSIZE_S  = SIZE_W'(bus.AWSIZE_M);
    assign bus.AWBURST_S = bus.AWBURST_M;
    assign bus.WDATA_S   = DATA_W'(bus.WDATA_M);
    assign bus.WSTRB_S   = (DATA_W/8)'(bus.WSTRB_M);
    assign bus.WLAST_S   = bus.WLAST_M;

    // Walk downwards so the lowest matching slave index is the one left in dec.
    always_comb begin
        dec = DEF;
        for (int i = NUM_S - 1; i >= 0; i--)
            if ((bus.AWADDR_M & SLV_MASK[i*ADDR_W +: ADDR_W]) == SLV_BASE[i*ADDR_W +: ADDR_W])
                dec = SEL_W'(i);
    end

    always_comb begin
        state_d       = state_q;
        sel_d         = sel_q;
        cnt_d         = cnt_q;
        len_d         = len_q;
        id_d          = id_q;
        wlast_err_d   = 1'b0;
        aw_rdy        = 1'b0;
        w_rdy         = 1'b0;
        b_vld         = 1'b0;
        bus.AWVALID_S = '0;
        bus.WVALID_S  = '0;
        bus.BREADY_S  = '0;
        bus.BRESP_M   = 2'b00;
        bus.BID_M     = '0;
        case (state_q)
            IDLE: begin
                aw_rdy = (dec == DEF);
                for (int i = 0; i < NUM_S; i++)
                    if (dec == SEL_W'(i)) begin
                        bus.AWVALID_S[i] = bus.AWVALID_M;
                        aw_rdy           = bus.AWREADY_S[i];
                    end
                if (bus.AWVALID_M && aw_rdy) begin
                    sel_d   = dec;
                    len_d   = bus.AWLEN_M;
                    id_d    = bus.AWID_M;
                    cnt_d   = '0;
                    state_d = WDATA;
                end
            end
            WDATA: begin
                w_rdy = (sel_q == DEF);
                for (int i = 0; i < NUM_S; i++)
                    if (sel_q == SEL_W'(i)) begin
                        bus.WVALID_S[i] = bus.WVALID_M;
                        w_rdy           = bus.WREADY_S[i];
                    end
                // WLAST alone ends the burst; the beat count only feeds the error flag.
                if (bus.WVALID_M && w_rdy) begin
                    cnt_d       = cnt_q + 1'b1;
                    wlast_err_d = bus.WLAST_M != (cnt_q == len_q);
                    if (bus.WLAST_M) state_d = WRESP;
                end
            end
            WRESP: begin
                b_vld       = (sel_q == DEF);
                bus.BRESP_M = 2'b11;
                bus.BID_M   = id_q;
                for (int i = 0; i < NUM_S; i++)
                    if (sel_q == SEL_W'(i)) begin
                        b_vld           = bus.BVALID_S[i];
                        bus.BRESP_M     = bus.BRESP_S[i];
                        bus.BID_M       = bus.BID_S[i][ID_W-1:0];
                        bus.BREADY_S[i] = bus.BREADY_M;
                    end
                if (b_vld && bus.BREADY_M) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
        bus.AWREADY_M = aw_rdy;
        bus.WREADY_M  = w_rdy;
        bus.BVALID_M  = b_vld;
    end

    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            state_q     <= IDLE;
            sel_q       <= '0;
            cnt_q       <= '0;
            len_q       <= '0;
            id_q        <= '0;
            wlast_err_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            sel_q       <= sel_d;
            cnt_q       <= cnt_d;
            len_q       <= len_d;
            id_q        <= id_d;
            wlast_err_q <= wlast_err_d;
        end
    end
endmodule
